// File: rtl/fmul_pkg.sv
// fmul_pkg: shared constants, operand classes and flag bundle for the fmul_pipe multiplier.
package fmul_pkg;

    typedef enum logic [1:0] {C_ZERO, C_NORM, C_INF, C_NAN} cls_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic invalid;
    } flags_t;

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic logic [63:0] qnan_frac(input int fw);
        return 64'd1 << (fw - 1);
    endfunction

endpackage

// File: rtl/fmul_mant_mult.sv
// fmul_mant_mult: registered unsigned mantissa multiplier, the S2 stage of fmul_pipe.
module fmul_mant_mult #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    always_ff @(posedge clk) begin
        if (rst) p <= '0;
        else if (en) p <= a * b;
    end

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FMUL_PIPE_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] b_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [FRAC_W-1:0] frac,
    output logic              overflow,
    output logic              underflow,
    output logic              invalid
);

    localparam int EW2 = EXP_W + 2;
    localparam int MW  = FRAC_W + 1;
    localparam int PW  = 2 * MW;
    localparam int RW  = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0]      EMAX   = EXP_W'(exp_max(EXP_W));
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(exp_max(EXP_W));

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    cls_t ca, cb;
    assign ca = a_exp == EMAX ? (a_frac != '0 ? C_NAN : C_INF) : a_exp == '0 ? C_ZERO : C_NORM;
    assign cb = b_exp == EMAX ? (b_frac != '0 ? C_NAN : C_INF) : b_exp == '0 ? C_ZERO : C_NORM;

    logic rs, is_nan, is_inv, is_inf, is_zero;
    assign rs      = a_sign ^ b_sign;
    assign is_nan  = ca == C_NAN || cb == C_NAN;
    assign is_inv  = (ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF);
    assign is_inf  = ca == C_INF || cb == C_INF;
    assign is_zero = ca == C_ZERO || cb == C_ZERO;

    // Special results are fully resolved in S1 and simply ride along the pipe.
    logic [RW-1:0] sp_res;
    assign sp_res = (is_nan || is_inv) ? {1'b0, EMAX, FRAC_W'(qnan_frac(FRAC_W))} :
                    is_inf ? {rs, EMAX, {FRAC_W{1'b0}}} : {rs, {(RW-1){1'b0}}};

    logic signed [EW2-1:0] esum;
    assign esum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(EW2'(bias(EXP_W)));

    logic v1, v2, s1, s2, sp1, sp2;
    logic signed [EW2-1:0] e1, e2;
    logic [RW-1:0] spr1, spr2;
    flags_t spf1, spf2;
    logic [MW-1:0] ma1, mb1;
    logic [PW-1:0] p;

    fmul_mant_mult #(.W(MW)) u_mult (
        .clk(clk), .rst(rst), .en(adv), .a(ma1), .b(mb1), .p(p)
    );

    // Product lies in [1,4); pre-shift so the leading one always sits at the top.
    logic hi;
    logic [PW-1:0] q;
    logic [MW-1:0] keep;
    logic [MW:0] rnd;
    assign hi   = p[PW-1];
    assign q    = hi ? p : p << 1;
    assign keep = q[PW-1 -: MW];
`ifdef FMUL_PIPE_RNE_EN
    logic g, st;
    assign g   = q[FRAC_W];
    assign st  = |q[FRAC_W-1:0];
    assign rnd = {1'b0, keep} + (MW+1)'(g & (st | keep[0]));
`else
    logic unused_lo;
    assign unused_lo = ^q[FRAC_W:0];
    assign rnd       = {1'b0, keep};
`endif
    logic unused_hid;
    assign unused_hid = rnd[FRAC_W];

    logic signed [EW2-1:0] e3;
    logic ovf, unf;
    logic [RW-1:0] res;
    flags_t fl;
    assign e3  = e2 + $signed({{(EW2-1){1'b0}}, hi}) + $signed({{(EW2-1){1'b0}}, rnd[MW]});
    assign ovf = e3 >= EMAX_S;
    assign unf = e3 <= 0;
    assign res = sp2 ? spr2 : ovf ? {s2, EMAX, {FRAC_W{1'b0}}} :
                 unf ? {s2, {(RW-1){1'b0}}} : {s2, e3[EXP_W-1:0], rnd[FRAC_W-1:0]};
    assign fl  = !v2 ? flags_t'(3'b000) : sp2 ? spf2 : flags_t'({ovf, unf, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, s1, s2, sp1, sp2} <= '0;
            {e1, e2, spr1, spr2, spf1, spf2, ma1, mb1} <= '0;
            out_valid <= 1'b0;
            {sign, exp, frac} <= '0;
            {overflow, underflow, invalid} <= '0;
        end else if (adv) begin
            v1   <= in_valid;
            s1   <= rs;
            e1   <= esum;
            sp1  <= is_nan | is_inf | is_zero;
            spr1 <= sp_res;
            spf1 <= flags_t'({2'b00, is_inv & ~is_nan});
            ma1  <= {a_exp != '0, a_frac};
            mb1  <= {b_exp != '0, b_frac};
            v2   <= v1;
            s2   <= s1;
            e2   <= e1;
            sp2  <= sp1;
            spr2 <= spr1;
            spf2 <= spf1;
            out_valid <= v2;
            {sign, exp, frac} <= res;
            {overflow, underflow, invalid} <= fl;
        end
    end

endmodule
